// File: rtl/trig_frame_decoder.sv
// Serial trigger-command frame decoder: start, 3-bit code (MSB first), even parity, stop.
// Emits one registered single-cycle pulse per frame: a trigger command or an error.
module trig_frame_decoder #(
    parameter int BIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trig_in,
    output logic       L1A,
    output logic       PL1A,
    output logic       PS,
    output logic       ALIGN,
    output logic       DELTA,
    output logic       err_parity,
    output logic       err_code,
    output logic       err_frame,
    output logic       busy,
    output logic [2:0] last_code
);

    localparam int HALF = (BIT_CYCLES - 1) / 2;
    localparam int CW   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    idx, idx_nxt;
    logic [2:0]    code, code_nxt;
    logic          par, par_nxt;
    logic [2:0]    last_nxt;
    // {err_frame, err_parity, err_code, DELTA, ALIGN, PS, PL1A, L1A}
    logic [7:0]    pulse, pulse_nxt;
    logic          bit_tick;

    function automatic logic [4:0] trig_onehot(input logic [2:0] c);
        case (c)
            3'b001:  trig_onehot = 5'b00001;
            3'b010:  trig_onehot = 5'b00010;
            3'b011:  trig_onehot = 5'b00100;
            3'b100:  trig_onehot = 5'b01000;
            3'b101:  trig_onehot = 5'b10000;
            default: trig_onehot = 5'b00000;
        endcase
    endfunction

    assign bit_tick = (cnt == CNT_LAST);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        code_nxt  = code;
        par_nxt   = par;
        last_nxt  = last_code;
        pulse_nxt = '0;
        case (state)
            IDLE: begin
                if (trig_in) begin
                    idx_nxt = '0;
                    // With no half-bit offset this sample already is the start bit.
                    if (HALF == 0) begin
                        state_nxt = DATA;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = START;
                        cnt_nxt   = CNT_ONE;
                    end
                end
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_nxt   = '0;
                    state_nxt = trig_in ? DATA : IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    cnt_nxt  = '0;
                    code_nxt = {code[1:0], trig_in};
                    if (idx == 2'd2) state_nxt = PARITY;
                    else             idx_nxt   = idx + 2'd1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    cnt_nxt   = '0;
                    par_nxt   = trig_in;
                    state_nxt = STOP;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    if (trig_in)                     pulse_nxt[7] = 1'b1;
                    else if ((^code) != par)         pulse_nxt[6] = 1'b1;
                    else if (trig_onehot(code) == 0) pulse_nxt[5] = 1'b1;
                    else begin
                        pulse_nxt[4:0] = trig_onehot(code);
                        last_nxt       = code;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            code      <= '0;
            par       <= 1'b0;
            pulse     <= '0;
            busy      <= 1'b0;
            last_code <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            code      <= code_nxt;
            par       <= par_nxt;
            pulse     <= pulse_nxt;
            busy      <= (state_nxt != IDLE);
            last_code <= last_nxt;
        end
    end

    assign {err_frame, err_parity, err_code, DELTA, ALIGN, PS, PL1A, L1A} = pulse;

endmodule

// File: tb/tb_trig_frame_decoder.sv
// Directed bench for trig_frame_decoder: table of frames at 4x oversampling plus
// glitch, mid-frame reset and back-to-back frames at 1x oversampling.
module tb_trig_frame_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       trig4, trig1;
    logic       l1a4, pl1a4, ps4, align4, delta4, ep4, ec4, ef4, busy4;
    logic       l1a1, pl1a1, ps1, align1, delta1, ep1, ec1, ef1, busy1;
    logic [2:0] last4, last1;
    logic [7:0] p4, p1;

    assign p4 = {ef4, ep4, ec4, delta4, align4, ps4, pl1a4, l1a4};
    assign p1 = {ef1, ep1, ec1, delta1, align1, ps1, pl1a1, l1a1};

    trig_frame_decoder #(.BIT_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .trig_in(trig4),
        .L1A(l1a4), .PL1A(pl1a4), .PS(ps4), .ALIGN(align4), .DELTA(delta4),
        .err_parity(ep4), .err_code(ec4), .err_frame(ef4),
        .busy(busy4), .last_code(last4)
    );

    trig_frame_decoder #(.BIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .trig_in(trig1),
        .L1A(l1a1), .PL1A(pl1a1), .PS(ps1), .ALIGN(align1), .DELTA(delta1),
        .err_parity(ep1), .err_code(ec1), .err_frame(ef1),
        .busy(busy1), .last_code(last1)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string      name;
        logic [5:0] frm;      // {start, code[2:0], parity, stop}
        logic [7:0] exp_p;    // {err_frame, err_parity, err_code, DELTA, ALIGN, PS, PL1A, L1A}
        logic [2:0] exp_last;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Outputs seen right after the negedge belong to cycle c; inputs driven here are sampled at the next posedge.
    task automatic step(input logic v4, input logic v1);
        @(negedge clk);
        trig4 = v4;
        trig1 = v1;
    endtask

    // One frame on the 4x decoder: t0 = cycle 0, result on cycle 22, busy over 1..21.
    task automatic run4(input string nm, input logic [5:0] frm, input logic [7:0] exp_p,
                        input logic [2:0] exp_l);
        logic [7:0] early, res, after;
        logic       b0, ball, b22;
        logic [2:0] lres;
        early = '0; res = '0; after = '0; b0 = 1'b0; ball = 1'b1; b22 = 1'b0; lres = '0;
        for (int c = 0; c < 26; c++) begin
            step((c < 22) ? frm[5 - c / 4] : 1'b0, 1'b0);
            if (c < 22) early |= p4;
            if (c == 0) b0 = busy4;
            if (c >= 1 && c <= 21) ball &= busy4;
            if (c == 22) begin res = p4; b22 = busy4; lres = last4; end
            if (c == 23) after = p4;
        end
        chk({nm, ".busy"}, {29'd0, b0, ball, b22}, 32'b010);
        chk({nm, ".early"}, {24'd0, early}, 32'd0);
        chk({nm, ".result"}, {24'd0, res}, {24'd0, exp_p});
        chk({nm, ".last"}, {29'd0, lres}, {29'd0, exp_l});
        chk({nm, ".after"}, {24'd0, after}, 32'd0);
    endtask

    initial begin
        logic [7:0] gp;
        logic       gb;
        logic [5:0] l1a_frm;
        int         npulse, nother, badgap, lastc, firstc;

        rst = 1'b0; trig4 = 1'b0; trig1 = 1'b0;
        repeat (3) step(1'b0, 1'b0);
        chk("reset.pulses4", {24'd0, p4}, 32'd0);
        chk("reset.busy4", {31'd0, busy4}, 32'd0);
        chk("reset.last4", {29'd0, last4}, 32'd0);
        chk("reset.pulses1", {24'd0, p1}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) step(1'b0, 1'b0);

        tbl[0]  = '{"l1a",          6'b100110, 8'h01, 3'b001};
        tbl[1]  = '{"pl1a",         6'b101010, 8'h02, 3'b010};
        tbl[2]  = '{"ps",           6'b101100, 8'h04, 3'b011};
        tbl[3]  = '{"align",        6'b110010, 8'h08, 3'b100};
        tbl[4]  = '{"delta",        6'b110100, 8'h10, 3'b101};
        tbl[5]  = '{"bad_parity",   6'b100100, 8'h40, 3'b101};
        tbl[6]  = '{"stop_one",     6'b100111, 8'h80, 3'b101};
        tbl[7]  = '{"code111",      6'b111110, 8'h20, 3'b101};
        tbl[8]  = '{"code000",      6'b100000, 8'h20, 3'b101};
        tbl[9]  = '{"code110",      6'b111000, 8'h20, 3'b101};
        tbl[10] = '{"stop_and_par", 6'b100101, 8'h80, 3'b101};
        tbl[11] = '{"par_and_rsvd", 6'b111100, 8'h40, 3'b101};
        tbl[12] = '{"l1a_again",    6'b100110, 8'h01, 3'b001};

        for (int i = 0; i < 13; i++)
            run4(tbl[i].name, tbl[i].frm, tbl[i].exp_p, tbl[i].exp_last);

        // Single-cycle glitch: start sample at t0+1 reads 0, so the frame aborts.
        gp = '0; gb = 1'b0;
        step(1'b1, 1'b0);
        for (int c = 1; c < 30; c++) begin
            step(1'b0, 1'b0);
            gp |= p4;
            if (c >= 2) gb |= busy4;
        end
        chk("glitch.pulses", {24'd0, gp}, 32'd0);
        chk("glitch.busy", {31'd0, gb}, 32'd0);
        chk("glitch.last", {29'd0, last4}, 32'b001);

        // Reset asserted while the decoder is in the middle of the code bits.
        l1a_frm = 6'b100110;
        for (int c = 0; c < 8; c++) step(l1a_frm[5 - c / 4], 1'b0);
        chk("midreset.busy_before", {31'd0, busy4}, 32'd1);
        rst = 1'b0;
        #1;
        chk("midreset.busy", {31'd0, busy4}, 32'd0);
        chk("midreset.pulses", {24'd0, p4}, 32'd0);
        chk("midreset.last", {29'd0, last4}, 32'd0);
        repeat (2) step(1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) step(1'b0, 1'b0);
        run4("post_reset_align", 6'b110010, 8'h08, 3'b100);

        // 1x oversampling: 100 back-to-back L1A frames, result six cycles after each t0.
        npulse = 0; nother = 0; badgap = 0; lastc = -1; firstc = -1;
        for (int c = 0; c < 612; c++) begin
            step(1'b0, (c < 600) ? l1a_frm[5 - (c % 6)] : 1'b0);
            if (p1[0]) begin
                npulse++;
                if (firstc < 0) firstc = c;
                else if (c - lastc != 6) badgap++;
                lastc = c;
            end
            if (p1[7:1] != 7'd0) nother++;
        end
        chk("b2b.count", npulse, 32'd100);
        chk("b2b.first", firstc, 32'd6);
        chk("b2b.gaps", badgap, 32'd0);
        chk("b2b.other", nother, 32'd0);
        chk("b2b.last", {29'd0, last1}, 32'b001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
